// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes and forwarding selects are combinational (0 cycles);
// the memory-wait FSM and the stall counter update on each rising edge; a slow dmem freezes the pipe up to MEM_TIMEOUT cycles.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       Rd_E,
    input  logic             Load_E,
    input  logic             PCSrc_E,
    input  logic [4:0]       Rd_M,
    input  logic             RegWrite_M,
    input  logic             dmem_req_M,
    input  logic             dmem_ready_M,
    input  logic [4:0]       Rd_W,
    input  logic             RegWrite_W,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             Flush_W,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_t;

    localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       lu, mw, memstall;

    assign lu       = Load_E && (Rd_E != 5'd0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
    assign mw       = dmem_req_M && !dmem_ready_M;
    assign memstall = ((state == RUN) || (state == MEM_WAIT)) && mw;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == rs))
            return 2'b10;
        else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (mw) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready_M) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = TIMEOUT;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            TIMEOUT: begin
                state_nxt    = RUN;
                wait_cnt_nxt = 8'd0;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    // A frozen EX stage holds PCSrc_E, so a redirect suppressed here is replayed once the stall lifts.
    always_comb begin
        Stall_F     = 1'b0;
        Stall_D     = 1'b0;
        Stall_E     = 1'b0;
        Stall_M     = 1'b0;
        Flush_D     = 1'b0;
        Flush_E     = 1'b0;
        Flush_W     = 1'b0;
        mem_timeout = 1'b0;
        ForwardA_E  = 2'b00;
        ForwardB_E  = 2'b00;
        if (rst_n) begin
            ForwardA_E = fwd_sel(Rs1_E);
            ForwardB_E = fwd_sel(Rs2_E);
            if (memstall) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Stall_E = 1'b1;
                Stall_M = 1'b1;
                Flush_W = 1'b1;
            end else if (state == TIMEOUT) begin
                mem_timeout = 1'b1;
                Flush_W     = 1'b1;
            end else if (PCSrc_E) begin
                Flush_D = 1'b1;
                Flush_E = 1'b1;
            end else if (lu) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Flush_E = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_count <= '0;
        else if (Stall_F && (stall_count != CNT_MAX))
            stall_count <= stall_count + CNT_ONE;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MEM_TIMEOUT=4 and a 4-bit stall counter so saturation is reachable.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic       Load_E, PCSrc_E, RegWrite_M, RegWrite_W, dmem_req_M, dmem_ready_M;
    logic       Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W, mem_timeout;
    logic [1:0] ForwardA_E, ForwardB_E;
    logic [3:0] stall_count;
    logic [7:0] ctl;
    logic [3:0] fwd;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    localparam logic [7:0] C_IDLE  = 8'b0000_0000;
    localparam logic [7:0] C_LU    = 8'b1100_0100;
    localparam logic [7:0] C_BR    = 8'b0000_1100;
    localparam logic [7:0] C_MEM   = 8'b1111_0010;
    localparam logic [7:0] C_TMO   = 8'b0000_0011;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
        .Load_E(Load_E), .PCSrc_E(PCSrc_E), .Rd_M(Rd_M), .RegWrite_M(RegWrite_M),
        .dmem_req_M(dmem_req_M), .dmem_ready_M(dmem_ready_M), .Rd_W(Rd_W), .RegWrite_W(RegWrite_W),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_W(Flush_W),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .mem_timeout(mem_timeout), .stall_count(stall_count)
    );

    assign ctl = {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W, mem_timeout};
    assign fwd = {ForwardA_E, ForwardB_E};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; Rd_E = 0; Rd_M = 0; Rd_W = 0;
        Load_E = 0; PCSrc_E = 0; RegWrite_M = 0; RegWrite_W = 0;
        dmem_req_M = 0; dmem_ready_M = 0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        // Reset: outputs forced low even with active hazards on the inputs.
        RegWrite_M = 1; Rd_M = 5; Rs1_E = 5; PCSrc_E = 1; dmem_req_M = 1;
        tick();
        tick();
        chk("reset_ctl", 32'(ctl), 32'(C_IDLE));
        chk("reset_fwd", 32'(fwd), 32'h0);
        chk("reset_cnt", 32'(stall_count), 32'd0);
        clear_inputs();
        rst_n = 1'b1;
        tick();

        // Forwarding
        RegWrite_M = 1; Rd_M = 5; RegWrite_W = 1; Rd_W = 5; Rs1_E = 5; Rs2_E = 0;
        #1 chk("fwd_m_prio", 32'(fwd), 32'b1000);
        Rd_M = 0;
        #1 chk("fwd_w_when_rdm0", 32'(fwd), 32'b0100);
        Rs1_E = 0; Rs2_E = 9; Rd_M = 9; Rd_W = 9;
        #1 chk("fwdb_m", 32'(fwd), 32'b0010);
        RegWrite_M = 0;
        #1 chk("fwdb_w", 32'(fwd), 32'b0001);
        RegWrite_W = 0;
        #1 chk("fwd_none", 32'(fwd), 32'b0000);
        chk("fwd_ctl_idle", 32'(ctl), 32'(C_IDLE));
        clear_inputs();
        tick();

        // Load-use on Rs2_D, then released
        Load_E = 1; Rd_E = 7; Rs2_D = 7;
        #1 chk("lu_rs2", 32'(ctl), 32'(C_LU));
        tick();
        clear_inputs();
        #1 chk("lu_released", 32'(ctl), 32'(C_IDLE));
        chk("lu_cnt1", 32'(stall_count), 32'd1);
        Load_E = 1; Rd_E = 0; Rs2_D = 0;
        #1 chk("lu_rd0", 32'(ctl), 32'(C_IDLE));
        tick();
        chk("lu_rd0_cnt", 32'(stall_count), 32'd1);
        Rd_E = 3; Rs1_D = 3;
        #1 chk("lu_rs1", 32'(ctl), 32'(C_LU));
        tick();
        Load_E = 0;
        #1 chk("no_load_no_lu", 32'(ctl), 32'(C_IDLE));
        chk("lu_cnt2", 32'(stall_count), 32'd2);
        clear_inputs();

        // Branch beats load-use
        Load_E = 1; Rd_E = 7; Rs2_D = 7; PCSrc_E = 1;
        #1 chk("branch_over_lu", 32'(ctl), 32'(C_BR));
        tick();
        chk("branch_cnt", 32'(stall_count), 32'd2);
        clear_inputs();

        // Memory wait of 3 cycles with a pending redirect
        PCSrc_E = 1; dmem_req_M = 1; dmem_ready_M = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("memwait_c%0d", i), 32'(ctl), 32'(C_MEM));
            tick();
        end
        dmem_ready_M = 1;
        #1 chk("memwait_ready_redirect", 32'(ctl), 32'(C_BR));
        chk("memwait_cnt", 32'(stall_count), 32'd5);
        tick();
        PCSrc_E = 0;
        #1 chk("first_cycle_ready", 32'(ctl), 32'(C_IDLE));
        tick();
        chk("first_cycle_ready_cnt", 32'(stall_count), 32'd5);
        clear_inputs();

        // Timeout, then re-entry while the request persists
        dmem_req_M = 1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("tmo_stall_c%0d", i), 32'(ctl), 32'(C_MEM));
            tick();
        end
        #1 chk("tmo_pulse", 32'(ctl), 32'(C_TMO));
        chk("tmo_cnt", 32'(stall_count), 32'd9);
        tick();
        #1 chk("tmo_reenter", 32'(ctl), 32'(C_MEM));
        tick();

        // Reset during MEM_WAIT
        rst_n = 1'b0;
        RegWrite_M = 1; Rd_M = 4; Rs2_E = 4;
        #1 chk("rst_mw_ctl", 32'(ctl), 32'(C_IDLE));
        chk("rst_mw_fwd", 32'(fwd), 32'h0);
        tick();
        chk("rst_mw_cnt", 32'(stall_count), 32'd0);
        rst_n = 1'b1;
        RegWrite_M = 0;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("post_rst_stall_c%0d", i), 32'(ctl), 32'(C_MEM));
            tick();
        end
        #1 chk("post_rst_tmo", 32'(ctl), 32'(C_TMO));
        chk("post_rst_cnt", 32'(stall_count), 32'd4);
        tick();
        clear_inputs();

        // Saturation of the 4-bit counter
        Load_E = 1; Rd_E = 2; Rs1_D = 2;
        for (int i = 0; i < 11; i++) tick();
        chk("sat_reach", 32'(stall_count), 32'd15);
        tick();
        tick();
        chk("sat_hold", 32'(stall_count), 32'd15);
        clear_inputs();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage RV64I core.
- Drives the enable and clear inputs of every pipeline register, including IF/ID (en = !Stall_D, clr = Flush_D).
- Resolves load-use hazards, data-memory wait states (with timeout) and taken-branch/jump redirects.
- Generates EX-stage forwarding selects and a saturating stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive MEM_WAIT cycles before forced release; legal range 2..255.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- Rs1_D  in  5  decode-stage source register 1.
- Rs2_D  in  5  decode-stage source register 2.
- Rs1_E  in  5  execute-stage source register 1.
- Rs2_E  in  5  execute-stage source register 2.
- Rd_E  in  5  execute-stage destination register.
- Load_E  in  1  execute-stage instruction is a load.
- PCSrc_E  in  1  taken branch or jump resolved in EX.
- Rd_M  in  5  memory-stage destination register.
- RegWrite_M  in  1  memory-stage instruction writes the register file.
- dmem_req_M  in  1  memory-stage data access is active.
- dmem_ready_M  in  1  data memory completes the access this cycle.
- Rd_W  in  5  writeback-stage destination register.
- RegWrite_W  in  1  writeback-stage instruction writes the register file.
- Stall_F  out  1  hold PC.
- Stall_D  out  1  hold IF/ID.
- Stall_E  out  1  hold ID/EX.
- Stall_M  out  1  hold EX/MEM.
- Flush_D  out  1  clear IF/ID to NOP.
- Flush_E  out  1  clear ID/EX to bubble.
- Flush_W  out  1  clear MEM/WB to bubble.
- ForwardA_E  out  2  operand A select: 00 = regfile, 01 = W result, 10 = M ALU result.
- ForwardB_E  out  2  operand B select, same encoding as ForwardA_E.
- mem_timeout  out  1  one-cycle pulse when MEM_TIMEOUT expires.
- stall_count  out  CNT_W  saturating count of cycles with Stall_F = 1.

Behaviour:
- Reset (rst_n = 0 at a clock edge):
  - state <= RUN, wait_cnt <= 0, stall_count <= 0, mem_timeout <= 0.
  - While rst_n = 0, all stall, flush and forward outputs are forced to 0.
- Forwarding (combinational, per operand, shown for Rs1_E):
  - RegWrite_M && Rd_M != 0 && Rd_M == Rs1_E -> 10.
  - Else RegWrite_W && Rd_W != 0 && Rd_W == Rs1_E -> 01.
  - Else 00. M has priority over W.
- Load-use hazard: lu = Load_E && Rd_E != 0 && (Rd_E == Rs1_D || Rd_E == Rs2_D).
- Memory wait: mw = dmem_req_M && !dmem_ready_M.
- FSM states:
  - RUN: if mw -> MEM_WAIT, wait_cnt <= 1.
  - MEM_WAIT:
    - dmem_ready_M -> RUN.
    - Else if wait_cnt == MEM_TIMEOUT-1 -> TIMEOUT.
    - Else wait_cnt <= wait_cnt + 1.
  - TIMEOUT: lasts one cycle, then RUN; wait_cnt <= 0.
- Output priority (combinational from state and inputs, highest first):
  1. memstall = (state == RUN || state == MEM_WAIT) && mw.
     - Stall_F = Stall_D = Stall_E = Stall_M = 1, Flush_W = 1.
     - Flush_D = Flush_E = 0, even if PCSrc_E or lu is set.
     - The redirect is deferred while EX is frozen, not lost.
  2. state == TIMEOUT.
     - mem_timeout = 1, Flush_W = 1, no stalls.
     - Access abandoned; the pipeline advances.
  3. PCSrc_E.
     - Flush_D = Flush_E = 1, no stalls.
     - A coincident lu is dropped, because the load-dependent instruction is on the wrong path.
  4. lu.
     - Stall_F = Stall_D = 1, Flush_E = 1, for exactly one cycle per hazard.
  5. Otherwise all stall and flush outputs are 0.
- Stall_E implies Stall_D implies Stall_F, always.
- Flush_D and Stall_D are never both 1.
- A dmem_ready_M arriving in the same cycle as the first request produces no stall and no state change.
- stall_count increments on each edge with Stall_F = 1 and rst_n = 1; it holds at 2^CNT_W-1.
- A reset during MEM_WAIT returns to RUN on the next edge; no mem_timeout pulse is issued.

Test Plan:
- Forwarding: RegWrite_M=1, Rd_M=5, RegWrite_W=1, Rd_W=5, Rs1_E=5, Rs2_E=0 -> ForwardA_E=10, ForwardB_E=00. Change Rd_M to 0 -> ForwardA_E=01.
- Load-use: Load_E=1, Rd_E=7, Rs2_D=7 for one cycle -> Stall_F=Stall_D=Flush_E=1 for 1 cycle, stall_count=1. Repeat with Rd_E=0 -> no stall.
- Branch vs load-use: PCSrc_E=1 with lu true -> Flush_D=Flush_E=1, Stall_F=0, stall_count unchanged.
- Memory wait: dmem_req_M=1, dmem_ready_M low for 3 cycles then high -> all four stalls plus Flush_W high for exactly 3 cycles; PCSrc_E=1 throughout gives Flush_D=0 during the stall and Flush_D=1 on the ready cycle; stall_count=3.
- Timeout: MEM_TIMEOUT=4, dmem_ready_M held low -> stalls for 4 cycles, then mem_timeout=1 for one cycle with no stalls, then MEM_WAIT re-entered if the request persists.
- Reset: rst_n=0 for one edge during MEM_WAIT -> all outputs 0, stall_count=0, state RUN; the next mw restarts wait_cnt at 1.
